// File: rtl/main_mem_pkg.sv
// +-----------------------------------------------------------------------+
// | main_mem_pkg : shared types and constants for the main-memory model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package main_mem_pkg;
   localparam int BLOCK_WORDS    = 4;
   localparam int DEFAULT_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/main_mem_array.sv
// +-----------------------------------------------------------------------+
// | main_mem_array : word storage, one write port, one block read port;   |
// | per-word even parity when MAIN_MEM_PARITY_EN is defined. Rev 1.0      |
// +-----------------------------------------------------------------------+
`default_nettype none

module main_mem_array
   import main_mem_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [31:0]                 wr_data,
   input  logic                        wr_perr_inj,
   input  logic [ADDR_W-3:0]           rd_blk,
   output logic [BLOCK_WORDS*32-1:0]   rd_data,
   output logic                        rd_perr
);

   logic [31:0] r_mem [0:2**ADDR_W-1];

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

`ifdef MAIN_MEM_PARITY_EN
   logic                   r_par [0:2**ADDR_W-1];
   logic [BLOCK_WORDS-1:0] w_bad;

   always_ff @(posedge clk) begin
      if (wr_en) r_par[wr_addr] <= (^wr_data) ^ wr_perr_inj;
   end

   assign rd_perr = |w_bad;
`else
   logic w_unused_perr;
   assign w_unused_perr = wr_perr_inj;
   assign rd_perr       = 1'b0;
`endif

   for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_rd
      localparam logic [1:0] c_off = 2'(i);
      logic [31:0] w_word;
      assign w_word             = r_mem[{rd_blk, c_off}];
      assign rd_data[32*i +: 32] = w_word;
`ifdef MAIN_MEM_PARITY_EN
      assign w_bad[i] = r_par[{rd_blk, c_off}] ^ (^w_word);
`endif
   end

endmodule

`default_nettype wire

// File: rtl/main_mem_responder.sv
// +-----------------------------------------------------------------------+
// | main_mem_responder : fixed-latency main-memory responder for a cache  |
// | controller. Optional parity: MAIN_MEM_PARITY_EN.  Rev 1.0             |
// +-----------------------------------------------------------------------+
`default_nettype none

module main_mem_responder
   import main_mem_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int LATENCY = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   input  logic                        req_write,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [31:0]                 req_wdata,
   input  logic                        req_perr_inj,
   output logic                        req_ready,
   output logic                        resp_valid,
   output logic [BLOCK_WORDS*32-1:0]   resp_block,
   output logic                        resp_err,
   output logic                        busy
);

   localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

   state_t                      r_state, w_next;
   logic [3:0]                  r_cnt, w_cnt_next;
   logic                        r_write, r_perr;
   logic [ADDR_W-1:0]           r_addr;
   logic [31:0]                 r_wdata;
   logic [BLOCK_WORDS*32-1:0]   r_block;
   logic                        r_err;

   logic                        w_accept, w_to_resp, w_is_write, w_rd_perr;
   logic [ADDR_W-3:0]           w_rd_blk;
   logic [BLOCK_WORDS*32-1:0]   w_rd_data;

   assign w_accept  = (r_state == IDLE) && req_valid;
   assign w_to_resp = (w_next == RESP) && (r_state != RESP);
   // With LATENCY=1 the response is captured on the accepting edge, before the latches settle.
   assign w_is_write = (r_state == IDLE) ? req_write : r_write;
   assign w_rd_blk   = (r_state == IDLE) ? req_addr[ADDR_W-1:2] : r_addr[ADDR_W-1:2];

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_cnt_next = c_lat_m1;
               w_next     = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (w_cnt_next == 4'd0) w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_perr  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_block <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_write <= req_write;
            r_perr  <= req_perr_inj;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_to_resp && !w_is_write) r_block <= w_rd_data;
         r_err <= w_to_resp && !w_is_write && w_rd_perr;
      end
   end

   main_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk         (clk),
      .wr_en       ((r_state == RESP) && r_write),
      .wr_addr     (r_addr),
      .wr_data     (r_wdata),
      .wr_perr_inj (r_perr),
      .rd_blk      (w_rd_blk),
      .rd_data     (w_rd_data),
      .rd_perr     (w_rd_perr)
   );

   assign req_ready  = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_block = r_block;
   assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_main_mem_responder.sv
// +-----------------------------------------------------------------------+
// | tb_main_mem_responder : bench for main_mem_responder (LATENCY 4 and 1)|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_main_mem_responder;

   localparam int LAT = 4;
`ifdef MAIN_MEM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid, req_write, req_perr_inj;
   logic [9:0]    req_addr;
   logic [31:0]   req_wdata;
   logic          req_ready, resp_valid, resp_err, busy;
   logic [127:0]  resp_block;

   logic          req_valid_1, req_write_1, req_perr_inj_1;
   logic [9:0]    req_addr_1;
   logic [31:0]   req_wdata_1;
   logic          req_ready_1, resp_valid_1, resp_err_1, busy_1;
   logic [127:0]  resp_block_1;

   main_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_perr_inj(req_perr_inj),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_block(resp_block),
      .resp_err(resp_err), .busy(busy)
   );

   main_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_write(req_write_1),
      .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_perr_inj(req_perr_inj_1),
      .req_ready(req_ready_1), .resp_valid(resp_valid_1), .resp_block(resp_block_1),
      .resp_err(resp_err_1), .busy(busy_1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_mem [1024];
   bit          m_inj [1024];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] m_block(input logic [9:0] a);
      int b;
      b = int'(a) & ~3;
      return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
   endfunction

   function automatic bit m_err(input logic [9:0] a);
      int b;
      b = int'(a) & ~3;
      return PAR && (m_inj[b] || m_inj[b+1] || m_inj[b+2] || m_inj[b+3]);
   endfunction

   // One request through the LATENCY=4 instance; returns the block seen at completion.
   task automatic txn(input bit wr, input logic [9:0] a, input logic [31:0] d, input bit pe,
                      input string tag, output logic [127:0] blk, output logic err);
      int n;
      int lat;
      bit got;
      logic [127:0] prev;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ready_before"}, 128'(req_ready), 128'(1));
      prev         = resp_block;
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = a;
      req_wdata    = d;
      req_perr_inj = pe;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 10'($urandom);
      req_wdata = $urandom;
      check({tag, " busy_wait"}, 128'(busy), 128'(1));
      lat = 1;
      got = 1'b0;
      while (lat <= 20) begin
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 128'(got ? lat : 0), 128'(LAT));
      blk = resp_block;
      err = resp_err;
      if (got) begin
         if (wr) begin
            check({tag, " block_held"}, resp_block, prev);
            check({tag, " err_wr"}, 128'(resp_err), 128'(0));
            m_mem[a] = d;
            m_inj[a] = pe;
         end else begin
            check({tag, " block"}, resp_block, m_block(a));
            check({tag, " err"}, 128'(resp_err), 128'(m_err(a)));
         end
         @(negedge clk);
         check({tag, " ready_after"}, 128'(req_ready), 128'(1));
      end
   endtask

   typedef struct {
      bit          wr;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          word;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t         tbl [7];
      logic [127:0] blk;
      logic         err;
      logic [31:0]  prior;
      int           accepts, pulses, prev_acc;

      tbl[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 0, 32'h0};
      tbl[1] = '{1'b0, 10'h004, 32'h0,        1, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 10'h3FF, 32'hCAFEF00D, 0, 32'h0};
      tbl[3] = '{1'b0, 10'h3FC, 32'h0,        3, 32'hCAFEF00D};
      tbl[4] = '{1'b1, 10'h006, 32'h0BADC0DE, 0, 32'h0};
      tbl[5] = '{1'b0, 10'h007, 32'h0,        2, 32'h0BADC0DE};
      tbl[6] = '{1'b0, 10'h005, 32'h0,        1, 32'hDEADBEEF};

      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_perr_inj = 0;
      req_valid_1 = 0; req_write_1 = 0; req_addr_1 = 0; req_wdata_1 = 0; req_perr_inj_1 = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset ready", 128'(req_ready), 128'(1));
      check("reset busy", 128'(busy), 128'(0));
      check("reset resp_valid", 128'(resp_valid), 128'(0));
      check("reset resp_block", resp_block, 128'(0));
      check("reset resp_err", 128'(resp_err), 128'(0));

      for (int a = 0; a < 64; a++) txn(1'b1, 10'(a), $urandom, 1'b0, "init", blk, err);
      for (int a = 10'h3FC; a <= 10'h3FF; a++) txn(1'b1, 10'(a), $urandom, 1'b0, "init", blk, err);

      for (int i = 0; i < 7; i++) begin
         txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, "table", blk, err);
         if (!tbl[i].wr) check("table word", 128'(blk[32*tbl[i].word +: 32]), 128'(tbl[i].exp));
      end

      // req_valid held high: one acceptance every LAT+1 cycles, one pulse each
      accepts = 0; pulses = 0; prev_acc = -1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h000;
      for (int c = 0; c < 30; c++) begin
         if (req_ready) begin
            if (prev_acc >= 0) check("hold gap", 128'(c - prev_acc), 128'(LAT + 1));
            prev_acc = c;
            accepts++;
         end
         if (resp_valid) pulses++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("hold accepts", 128'(accepts), 128'(6));
      check("hold pulses", 128'(pulses), 128'(6));

      // reset in the second WAIT cycle of a write aborts it
      prior = m_mem[16];
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h010; req_wdata = 32'h1234;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort ready", 128'(req_ready), 128'(1));
      check("abort busy", 128'(busy), 128'(0));
      check("abort block", resp_block, 128'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      txn(1'b0, 10'h010, 32'h0, 1'b0, "abort read", blk, err);
      check("abort word", 128'(blk[31:0]), 128'(prior));

      // injected parity error is reported only when parity is built in
      txn(1'b1, 10'h020, 32'h13572468, 1'b1, "perr wr", blk, err);
      txn(1'b0, 10'h020, 32'h0, 1'b0, "perr rd", blk, err);
      check("perr flagged", 128'(err), 128'(PAR));
      txn(1'b0, 10'h000, 32'h0, 1'b0, "clean rd", blk, err);
      check("clean no err", 128'(err), 128'(0));

      for (int i = 0; i < 80; i++) begin
         logic [9:0] a;
         a = ($urandom_range(4) == 0) ? 10'(10'h3FC + $urandom_range(3)) : 10'($urandom_range(63));
         txn(1'($urandom), a, $urandom, ($urandom_range(5) == 0), "rand", blk, err);
      end

      // LATENCY=1 instance
      req_valid_1 = 1'b1; req_write_1 = 1'b1; req_addr_1 = 10'h008; req_wdata_1 = 32'hA5A50001;
      @(negedge clk);
      req_valid_1 = 1'b0;
      check("lat1 wr resp", 128'(resp_valid_1), 128'(1));
      check("lat1 wr ready_low", 128'(req_ready_1), 128'(0));
      @(negedge clk);
      check("lat1 wr ready", 128'(req_ready_1), 128'(1));
      check("lat1 wr pulse_end", 128'(resp_valid_1), 128'(0));
      req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = 10'h00A;
      @(negedge clk);
      req_valid_1 = 1'b0;
      check("lat1 rd resp", 128'(resp_valid_1), 128'(1));
      check("lat1 rd word0", 128'(resp_block_1[31:0]), 128'(32'hA5A50001));
      @(negedge clk);
      check("lat1 rd ready", 128'(req_ready_1), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
